memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive data-word completions allowed while iREN is pending before instruction gets priority (legal range 1..7).
REQ-002 CLK  in  1  single clock, all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 iREN  in  1 / iaddr  in  32 / iwait  out  1 / iload  out  32  icache port.
REQ-005 dREN  in  1 / dWEN  in  1 / daddr  in  32 / dstore  in  32 / dwait  out  1 / dload  out  32  dcache port; each dcache block is 2 words (daddr[2] selects word).
REQ-006 ramREN  out  1 / ramWEN  out  1 / ramaddr  out  32 / ramstore  out  32  RAM request.
REQ-007 ramload  in  32 / ramstate  in  2  RAM response; encoding FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-008 ram_err  out  1  sticky error flag.

Function
REQ-009 FSM states IDLE, DGRANT, IGRANT; state register, starvation counter (3 bits) and burst-lock bit update only on CLK rising edge.
REQ-010 IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
REQ-011 IDLE arbitration: data request = dREN|dWEN; if only data requests -> DGRANT; if only iREN -> IGRANT; if both -> IGRANT when starve count >= STARVE_MAX, else DGRANT; none -> stay IDLE.
REQ-012 Grant takes effect the cycle after arbitration (one-cycle turnaround from IDLE).
REQ-013 DGRANT: ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both); ramstore=dstore; iwait=1.
REQ-014 IGRANT: ramaddr=iaddr; ramREN=1; ramWEN=0; ramstore=0; dwait=1.
REQ-015 Owner wait is 0 exactly in cycles where state grants it and ramstate==ACCESS, else 1; non-owner wait always 1.
REQ-016 iload and dload both combinationally equal ramload at all times (qualified by wait).
REQ-017 Completion (ramstate==ACCESS) in IGRANT -> IDLE; starve count cleared to 0.
REQ-018 Completion in DGRANT with daddr[2]==0 -> stay DGRANT (burst lock) for the second word, no IDLE bubble; with daddr[2]==1 -> IDLE.
REQ-019 Burst lock overrides starvation priority; an instruction request never splits a data block.
REQ-020 Each data-word completion while iREN is high increments starve count, saturating at 7; data completion with iREN low clears it to 0.
REQ-021 Owner dropping its request while granted and before ACCESS -> IDLE next cycle, RAM outputs deasserted that same cycle (driven from live request), no counter change.
REQ-022 ramstate==ERROR while granted: owner wait stays 1, ram_err set (remains 1 until RST), FSM -> IDLE and transaction is re-arbitrated (retried) if still requested.
REQ-023 ramstate FREE or BUSY while granted: hold state and outputs unchanged.
REQ-024 All outputs are glitch-free functions of state and current inputs; no combinational path from ramload to any control output.

Reset
REQ-025 RST high at a rising edge: state=IDLE, starve count=0, burst lock=0, ram_err=0; takes priority over any in-flight grant, including mid-burst.
REQ-026 Outputs during/after reset follow REQ-010 (iwait=dwait=1, RAM controls 0).

Verification
REQ-027 iREN=1, iaddr=0x40, RAM ACCESS 2 cycles after grant, ramload=0x1234 -> IGRANT at cycle 1, iwait=0 with iload=0x1234 in ACCESS cycle, IDLE next.
REQ-028 dWEN=1 daddr=0x100 dstore=0xAA then daddr=0x104 dstore=0xBB, iREN=1 throughout -> two consecutive RAM writes with no IDLE between, iwait=1 throughout, then IGRANT not before IDLE.
REQ-029 STARVE_MAX=4, dREN and iREN held high, single-word data accesses at daddr[2]=1 -> 4 data completions then IGRANT; count reset to 0 after instruction completes.
REQ-030 dREN=1 dWEN=1 simultaneously -> ramWEN=1, ramREN=0.
REQ-031 ramstate=ERROR during DGRANT -> ram_err=1, dwait=1, IDLE, then re-grant DGRANT and complete on next ACCESS; ram_err stays 1.
REQ-032 RST asserted in DGRANT between burst words -> next cycle IDLE, ramWEN=ramREN=0, ram_err=0, starve count=0.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates one RAM port between an icache (single-word fetches) and a dcache
// (two-word blocks), with a starvation limit on instruction waits and a sticky error flag.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  // icache port
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache port
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] STARVE_SAT = {CNT_W{1'b1}};

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  logic d_req;
  logic starved;
  logic ram_access;
  logic ram_error;

  assign d_req      = dREN | dWEN;
  assign starved    = (starve_q >= STARVE_LIM);
  assign ram_access = (ramstate == RAM_ACCESS);
  assign ram_error  = (ramstate == RAM_ERROR);

  // Next-state, starvation counter, burst lock and error flag.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        lock_d = 1'b0;
        if (d_req && (!iREN || !starved)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
          lock_d  = 1'b0;
        end else if (ram_error) begin
          err_d   = 1'b1;
          state_d = IDLE;
          lock_d  = 1'b0;
        end else if (ram_access) begin
          if (!iREN) begin
            starve_d = '0;
          end else if (starve_q != STARVE_SAT) begin
            starve_d = starve_q + CNT_W'(1);
          end
          // A low-word completion keeps the grant for the second word of the block.
          if (!lock_q && !daddr[2]) begin
            lock_d = 1'b1;
          end else begin
            lock_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_error) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ram_access) begin
          starve_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        lock_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  // RAM request and cache handshakes follow the grant and the live request lines.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramstore = dstore;
        dwait    = ~ram_access;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~ram_access;
      end
      default: ;
    endcase
  end

  assign iload   = ramload;
  assign dload   = ramload;
  assign ram_err = err_q;

endmodule
